// File: rtl/restador_pkg.sv
// Shared types for the bit-serial subtractor.
package restador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rs_state_t;

endpackage

// File: rtl/medio_restador.sv
// One-bit half subtractor: d = a - b, bout set when b exceeds a.
module medio_restador (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);

    assign d    = a ^ b;
    assign bout = ~a & b;

endmodule

// File: rtl/restador_completo.sv
// One-bit full subtractor: d = a - b - bin, built from two half subtractors.
module restador_completo (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    medio_restador u_hs0 (
        .a    (a),
        .b    (b),
        .d    (d1),
        .bout (b1)
    );

    medio_restador u_hs1 (
        .a    (d1),
        .b    (bin),
        .d    (d),
        .bout (b2)
    );

    assign bout = b1 | b2;

endmodule

// File: rtl/restador_serie.sv
// Bit-serial subtractor dif = a - b, one bit per clock, LSB first, with
// start/done handshake plus final borrow and signed-overflow flags.
module restador_serie
    import restador_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dif,
    output logic             borrow,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    rs_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dif_q, dif_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic             bit_d;
    logic             bit_bout;
    logic [WIDTH-1:0] shift_w;

    restador_completo u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // Partial result with the current bit entering from the MSB side.
    assign shift_w = {bit_d, res_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            dif_q    <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            dif_q    <= dif_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        dif_d    = dif_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = bit_bout;
                res_d = shift_w[WIDTH-1:1];
                cnt_d = cnt_q + CW'(1);
                // On the last bit a_q[0]/b_q[0] hold the latched operand MSBs.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    dif_d    = shift_w;
                    borrow_d = bit_bout;
                    ovf_d    = (a_q[0] != b_q[0]) && (bit_d != a_q[0]);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        dif    = dif_q;
        borrow = borrow_q;
        ovf    = ovf_q;
    end

endmodule

// File: tb/tb_restador_serie.sv
// Self-checking bench for restador_serie at WIDTH=8 and WIDTH=4.
module tb_restador_serie;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, borrow8, ovf8;
    logic [7:0] dif8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4, done4, borrow4, ovf4;
    logic [3:0] dif4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    restador_serie #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .dif    (dif8),
        .borrow (borrow8),
        .ovf    (ovf8)
    );

    restador_serie #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .start  (start4),
        .a      (a4),
        .b      (b4),
        .busy   (busy4),
        .done   (done4),
        .dif    (dif4),
        .borrow (borrow4),
        .ovf    (ovf4)
    );

    function automatic logic       busy_obs(input int w);   return (w == 8) ? busy8 : busy4;   endfunction
    function automatic logic       done_obs(input int w);   return (w == 8) ? done8 : done4;   endfunction
    function automatic logic       br_obs(input int w);     return (w == 8) ? borrow8 : borrow4; endfunction
    function automatic logic       ovf_obs(input int w);    return (w == 8) ? ovf8 : ovf4;     endfunction
    function automatic logic [7:0] dif_obs(input int w);    return (w == 8) ? dif8 : {4'b0, dif4}; endfunction

    task automatic set_in(input int w, input logic s, input logic [7:0] av, input logic [7:0] bv);
        if (w == 8) begin
            start8 = s; a8 = av; b8 = bv;
        end else begin
            start4 = s; a4 = av[3:0]; b4 = bv[3:0];
        end
    endtask

    // Arithmetic reference: modular difference, unsigned compare, signed range check.
    function automatic void model(input int w, input int av, input int bv,
                                  output logic [7:0] ed, output logic eb, output logic eo);
        int m, sa, sb, sd;
        m  = 1 << w;
        ed = 8'((av - bv + m) % m);
        eb = (av < bv);
        sa = (av >= m / 2) ? av - m : av;
        sb = (bv >= m / 2) ? bv - m : bv;
        sd = sa - sb;
        eo = (sd >= m / 2) || (sd < -(m / 2));
    endfunction

    // mode 0: plain op; 1: start with a=b=1 in 3rd RUN cycle; 2: rst in 4th RUN cycle.
    task automatic do_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input int mode, input string nm);
        logic [7:0] prev_d;
        prev_d = dif_obs(w);
        set_in(w, 1'b1, av, bv);
        @(posedge clk); #1;
        for (int i = 1; i <= w; i++) begin
            set_in(w, (mode == 1 && i == 3), (mode == 1 && i == 3) ? 8'd1 : 8'($urandom_range(0, 255)),
                   (mode == 1 && i == 3) ? 8'd1 : 8'($urandom_range(0, 255)));
            if (mode == 2 && i == 4) rst = 1'b1;
            @(posedge clk); #1;
            if (mode == 2 && i == 4) begin
                rst = 1'b0;
                n_cmp++;
                if ({busy_obs(w), done_obs(w), dif_obs(w), br_obs(w), ovf_obs(w)} !== 12'h0) begin
                    n_fail++;
                    $display("FAIL %s reset_outputs: busy=%0b done=%0b dif=%h br=%0b ovf=%0b, want all 0",
                             nm, busy_obs(w), done_obs(w), dif_obs(w), br_obs(w), ovf_obs(w));
                end
                for (int j = 0; j < 12; j++) begin
                    @(posedge clk); #1;
                    n_cmp++;
                    if (busy_obs(w) !== 1'b0 || done_obs(w) !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s post_reset_idle cyc%0d: busy=%0b done=%0b, want 0 0",
                                 nm, j, busy_obs(w), done_obs(w));
                    end
                end
                return;
            end
            if (i < w) begin
                n_cmp++;
                if (busy_obs(w) !== 1'b1 || done_obs(w) !== 1'b0 || dif_obs(w) !== prev_d) begin
                    n_fail++;
                    $display("FAIL %s run_cyc%0d: busy=%0b done=%0b dif=%h, want 1 0 %h",
                             nm, i, busy_obs(w), done_obs(w), dif_obs(w), prev_d);
                end
            end else begin
                n_cmp++;
                if (busy_obs(w) !== 1'b1 || done_obs(w) !== 1'b1 || dif_obs(w) !== ed ||
                    br_obs(w) !== eb || ovf_obs(w) !== eo) begin
                    n_fail++;
                    $display("FAIL %s done: busy=%0b done=%0b dif=%h br=%0b ovf=%0b, want 1 1 %h %0b %0b",
                             nm, busy_obs(w), done_obs(w), dif_obs(w), br_obs(w), ovf_obs(w), ed, eb, eo);
                end
            end
        end
        set_in(w, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        @(posedge clk); #1;
        n_cmp++;
        if (busy_obs(w) !== 1'b0 || done_obs(w) !== 1'b0 || dif_obs(w) !== ed ||
            br_obs(w) !== eb || ovf_obs(w) !== eo) begin
            n_fail++;
            $display("FAIL %s after_done: busy=%0b done=%0b dif=%h br=%0b ovf=%0b, want 0 0 %h %0b %0b",
                     nm, busy_obs(w), done_obs(w), dif_obs(w), br_obs(w), ovf_obs(w), ed, eb, eo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int w = 4; w <= 8; w += 4) begin
            n_cmp++;
            if ({busy_obs(w), done_obs(w), dif_obs(w), br_obs(w), ovf_obs(w)} !== 12'h0) begin
                n_fail++;
                $display("FAIL reset_w%0d: busy=%0b done=%0b dif=%h br=%0b ovf=%0b, want all 0",
                         w, busy_obs(w), done_obs(w), dif_obs(w), br_obs(w), ovf_obs(w));
            end
        end
    endtask

    task automatic test_directed();
        do_op(8, 8'd5,   8'd3,   8'h02, 1'b0, 1'b0, 0, "sub_5_3");
        do_op(8, 8'd3,   8'd5,   8'hFE, 1'b1, 1'b0, 0, "sub_3_5");
        do_op(8, 8'd0,   8'd0,   8'h00, 1'b0, 1'b0, 0, "sub_0_0");
        do_op(8, 8'h80,  8'h01,  8'h7F, 1'b0, 1'b1, 0, "sub_80_01");
        do_op(8, 8'h7F,  8'hFF,  8'h80, 1'b1, 1'b1, 0, "sub_7f_ff");
    endtask

    task automatic test_start_while_busy();
        do_op(8, 8'd5, 8'd3, 8'h02, 1'b0, 1'b0, 1, "start_busy");
    endtask

    task automatic test_reset_midrun();
        do_op(8, 8'd200, 8'd17, 8'h00, 1'b0, 1'b0, 2, "rst_midrun");
        do_op(8, 8'd9, 8'd4, 8'h05, 1'b0, 1'b0, 0, "sub_9_4");
    endtask

    task automatic test_width4();
        do_op(4, 8'hF, 8'hF, 8'h0, 1'b0, 1'b0, 0, "w4_f_f");
        do_op(4, 8'h0, 8'h1, 8'hF, 1'b1, 1'b0, 0, "w4_0_1");
    endtask

    task automatic test_random();
        logic [7:0] ed;
        logic       eb, eo;
        int         av, bv;
        for (int n = 0; n < 40; n++) begin
            int w;
            w  = (n % 4 == 3) ? 4 : 8;
            av = $urandom_range(0, (1 << w) - 1);
            bv = $urandom_range(0, (1 << w) - 1);
            model(w, av, bv, ed, eb, eo);
            do_op(w, 8'(av), 8'(bv), ed, eb, eo, 0, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_reset_midrun();
        test_width4();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
